modexp_host_bridge: RTL

Host-side sequencer placed directly upstream and downstream of `ModExp`. It accepts a 4096-bit operand as a 32-bit valid/ready stream and packs it into 128-bit words. It replays those words to `ModExp` using that core's startInput/inp/startCompute protocol, waits for the core's terminal state, then collects the 32 result words via getResult and returns them as a 32-bit valid/ready stream. It also reports the compute latency in cycles.

---
 rtl/modexp_host_bridge_pkg.sv | 21 ++
 rtl/modexp_word_buf.sv | 33 +++
 rtl/modexp_host_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/modexp_host_bridge_pkg.sv
// Shared ModExp constants and the host bridge sequencer state encoding.
package modexp_host_bridge_pkg;

    localparam int DATA_WIDTH = 128;
    localparam int WORD_COUNT = 32;
    localparam int HOST_WIDTH = 32;
    localparam logic [4:0] TERMINAL = 5'd17;
    localparam int GAP_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PULSE,
        SEND,
        GAP,
        COMPUTE,
        FETCH,
        DRAIN
    } bridge_state_t;

endpackage

// File: rtl/modexp_word_buf.sv
// WORD_COUNT x DATA_WIDTH register file: one slice-masked write port, one async read port.
// Latency: write visible next cycle, read combinational; no backpressure.
module modexp_word_buf
    import modexp_host_bridge_pkg::*;
#(
    parameter int HW = HOST_WIDTH,
    localparam int SLICES = DATA_WIDTH / HW,
    localparam int AW = $clog2(WORD_COUNT)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [SLICES-1:0]     wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [WORD_COUNT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int s = 0; s < SLICES; s++) begin
                if (wr_mask[s]) begin
                    mem[wr_addr][s*HW +: HW] <= wr_dat[s*HW +: HW];
                end
            end
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/modexp_host_bridge.sv
// Host-stream to ModExp sequencer: packs operand, replays it to the core, drains the result.
// Latency: pulse 1 cycle after last host word, compute starts 3 cycles after last inp word; host streams are valid/ready.
module modexp_host_bridge
    import modexp_host_bridge_pkg::*;
#(
    parameter int HOST_WIDTH     = modexp_host_bridge_pkg::HOST_WIDTH,
    parameter int RESULT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [HOST_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [HOST_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  startInput,
    output logic                  startCompute,
    output logic                  getResult,
    output logic [DATA_WIDTH-1:0] inp,
    input  logic [4:0]            stateModExp,
    input  logic [DATA_WIDTH-1:0] outp,
    output logic                  busy,
    output logic [31:0]           cycles
);

    localparam int SLICES = DATA_WIDTH / HOST_WIDTH;
    localparam int AW     = $clog2(WORD_COUNT);
    localparam int SW     = $clog2(SLICES);
    localparam int WMAX   = (RESULT_LATENCY > GAP_CYCLES) ? RESULT_LATENCY : GAP_CYCLES;
    localparam int WTW    = $clog2(WMAX + 1);

    bridge_state_t state, state_nxt;

    logic [AW-1:0]         widx;
    logic [SW-1:0]         sidx;
    logic [WTW-1:0]        wait_cnt;
    logic                  s_hs, m_hs;
    logic                  last_word, last_slice, lat_done, gap_done;
    logic                  wr_en;
    logic [SLICES-1:0]     wr_mask;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign s_ready    = (state == IDLE) || (state == LOAD);
    assign m_valid    = (state == DRAIN);
    assign busy       = (state != IDLE);
    assign s_hs       = s_valid && s_ready;
    assign m_hs       = m_valid && m_ready;
    assign last_word  = (widx == AW'(WORD_COUNT - 1));
    assign last_slice = (sidx == SW'(SLICES - 1));
    assign lat_done   = (wait_cnt == WTW'(RESULT_LATENCY));
    assign gap_done   = (wait_cnt == WTW'(GAP_CYCLES - 1));
    assign m_data     = m_valid ? rd_dat[sidx*HOST_WIDTH +: HOST_WIDTH] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_valid) state_nxt = LOAD;
            LOAD:    if (s_hs && last_word && last_slice) state_nxt = PULSE;
            PULSE:   state_nxt = SEND;
            SEND:    if (last_word) state_nxt = GAP;
            GAP:     if (gap_done) state_nxt = COMPUTE;
            COMPUTE: if (stateModExp == TERMINAL) state_nxt = FETCH;
            FETCH:   if (lat_done && last_word) state_nxt = DRAIN;
            DRAIN:   if (m_hs && last_word && last_slice) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word/slice indices are shared by every phase; each phase leaves them at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            widx     <= '0;
            sidx     <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE, LOAD, DRAIN: begin
                    if (s_hs || m_hs) begin
                        sidx <= last_slice ? '0 : sidx + SW'(1);
                        if (last_slice) widx <= last_word ? '0 : widx + AW'(1);
                    end
                end
                SEND: widx <= last_word ? '0 : widx + AW'(1);
                GAP:  wait_cnt <= gap_done ? '0 : wait_cnt + WTW'(1);
                FETCH: begin
                    if (!lat_done) begin
                        wait_cnt <= wait_cnt + WTW'(1);
                    end else begin
                        widx <= last_word ? '0 : widx + AW'(1);
                        if (last_word) wait_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en  = s_hs || ((state == FETCH) && lat_done);
        wr_dat = (state == FETCH) ? outp : {SLICES{s_data}};
        for (int s = 0; s < SLICES; s++) begin
            wr_mask[s] = (state == FETCH) || (sidx == SW'(s));
        end
    end

    // Read one word ahead during replay so inp can be registered without a gap.
    always_comb begin
        rd_addr = widx;
        if (state == PULSE) begin
            rd_addr = '0;
        end else if (state == SEND) begin
            rd_addr = widx + AW'(1);
        end
    end

    modexp_word_buf #(
        .HW (HOST_WIDTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (widx),
        .wr_mask (wr_mask),
        .wr_dat  (wr_dat),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            startInput   <= 1'b0;
            startCompute <= 1'b0;
            getResult    <= 1'b0;
            inp          <= '0;
            cycles       <= '0;
        end else begin
            startInput   <= (state_nxt == PULSE);
            startCompute <= (state_nxt == COMPUTE) || (state_nxt == FETCH);
            getResult    <= (state_nxt == FETCH);
            if ((state == PULSE) || ((state == SEND) && !last_word)) begin
                inp <= rd_dat;
            end
            if ((state != COMPUTE) && (state_nxt == COMPUTE)) begin
                cycles <= '0;
            end else if (state == COMPUTE) begin
                cycles <= cycles + 32'd1;
            end
        end
    end

endmodule
